// File: rtl/matrix_add_pkg.sv
// ---------------------------------------------------------------------------
// matrix_add_pkg
//   Types and defaults shared by the matrix-add row sequencer, its delay
//   line, and anything that needs to reason about its end-to-end latency.
//   - seq_state_e   : sequencer FSM state encoding (IDLE, ISSUE, DRAIN, DONE)
//   - *_DEFAULT     : default ROWS / COLS / IN_WIDTH for the matrix add
//   - latency_total : cycles from an accepted start to the done pulse,
//                     counting both the start cycle and the done cycle
// ---------------------------------------------------------------------------
package matrix_add_pkg;

  localparam int ROWS_DEFAULT     = 10;
  localparam int COLS_DEFAULT     = 12;
  localparam int IN_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Start cycle + one issue cycle per row + read and add pipeline + done cycle.
  // An empty operation is just the start cycle followed by the done cycle.
  function automatic int latency_total(input int n_rows, input int rd_lat,
                                       input int add_lat);
    return (n_rows == 0) ? 2 : (n_rows + rd_lat + add_lat + 2);
  endfunction

endpackage

// File: rtl/enable_delay_line.sv
// ---------------------------------------------------------------------------
// enable_delay_line
//   1-bit shift register that only advances on enabled cycles, so a strobe
//   entering it emerges DEPTH enabled cycles later. DEPTH=0 is a wire.
//   Ports:
//     clk    in  clock
//     reset  in  synchronous active-high reset, clears every stage
//     enable in  advance the shift register this cycle
//     din    in  strobe entering the line
//     dout   out strobe leaving the line
// ---------------------------------------------------------------------------
module enable_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_sr
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (reset) begin
        sr <= '0;
      end else if (enable) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/matrix_add_row_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_add_row_sequencer
//   Drives one matrix add through a shared registered vector adder, one row
//   per cycle: issues A/B row reads, raises the adder's inReady once the row
//   data arrives, counts the adder's outReady pulses into result-memory
//   writes, and pulses done when every row has been written.
//
//   Optional feature: define MATRIX_SEQ_PERF_CNT_EN to add cycleCount, the
//   number of enabled busy cycles of the most recent operation.
//
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     enable       global clock enable shared with the adder
//     start        one-cycle operation request (accepted only in IDLE)
//     numRows      rows to process, sampled on accepted start, clamped to ROWS
//     rdEn/rdAddr  A/B row-memory read strobe and row index
//     addInReady   adder input strobe (rdEn delayed by RD_LATENCY)
//     addOutReady  adder result strobe
//     wrEn/wrAddr  result-memory write strobe and row index
//     busy         operation in progress (ISSUE, DRAIN, DONE)
//     done         one-cycle completion pulse
//     err          sticky protocol error, cleared only by reset
//     dbg_state    current FSM state
//     cycleCount   (MATRIX_SEQ_PERF_CNT_EN only) enabled busy cycles
//
//   Strobe semantics: rdEn, addInReady, wrEn and done are single-cycle
//   qualifiers with no back-pressure; each is only meaningful in a cycle with
//   enable=1 and is forced low whenever enable=0. addOutReady is a pure
//   valid: it is consumed as a write only while a row is outstanding, and any
//   other enabled pulse is dropped and flagged in err.
// ---------------------------------------------------------------------------
module matrix_add_row_sequencer
  import matrix_add_pkg::*;
#(
  parameter int ROWS        = ROWS_DEFAULT,
  parameter int COLS        = COLS_DEFAULT,
  parameter int ADD_LATENCY = 1,
  parameter int RD_LATENCY  = 1,
  parameter int ROW_W       = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [ROW_W-1:0] numRows,
  output logic             rdEn,
  output logic [ROW_W-1:0] rdAddr,
  output logic             addInReady,
  input  logic             addOutReady,
  output logic             wrEn,
  output logic [ROW_W-1:0] wrAddr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output seq_state_e       dbg_state
`ifdef MATRIX_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      cycleCount
`endif
);

  // COLS only sizes the adder; ADD_LATENCY only shapes the drain time, which
  // the write counter tracks directly. Both are still sanity-checked here.
  if (ROWS < 1 || COLS < 1 || ADD_LATENCY < 0 || RD_LATENCY < 0) begin : g_param_check
    $error("matrix_add_row_sequencer: illegal parameterisation");
  end

  localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] ONE      = ROW_W'(1);

  seq_state_e       state, state_nxt;
  logic [ROW_W-1:0] n_rows, n_rows_nxt;
  logic [ROW_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [ROW_W-1:0] wr_cnt, wr_cnt_nxt;
  logic             err_q, err_nxt;
  logic             rd_en, wr_en, done_int;
  logic             num_ovf;
  logic [ROW_W-1:0] n_clamped;
  logic             wr_ok;
  logic             dl_q;

  assign num_ovf   = (numRows > ROWS_MAX);
  assign n_clamped = num_ovf ? ROWS_MAX : numRows;

  // A result is expected only while the operation is live and rows remain.
  assign wr_ok = ((state == ISSUE) || (state == DRAIN)) && (wr_cnt != n_rows);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      n_rows <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_q  <= 1'b0;
    end else if (enable) begin
      state  <= state_nxt;
      n_rows <= n_rows_nxt;
      rd_cnt <= rd_cnt_nxt;
      wr_cnt <= wr_cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    n_rows_nxt = n_rows;
    rd_cnt_nxt = rd_cnt;
    wr_cnt_nxt = wr_cnt;
    err_nxt    = err_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done_int   = 1'b0;

    if (addOutReady) begin
      if (wr_ok) begin
        wr_en      = 1'b1;
        wr_cnt_nxt = wr_cnt + ONE;
      end else begin
        err_nxt = 1'b1;
      end
    end

    if (start && (state != IDLE)) begin
      err_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          n_rows_nxt = n_clamped;
          rd_cnt_nxt = '0;
          wr_cnt_nxt = '0;
          if (num_ovf) begin
            err_nxt = 1'b1;
          end
          state_nxt = (n_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_en      = 1'b1;
        rd_cnt_nxt = rd_cnt + ONE;
        if (rd_cnt == n_rows - ONE) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Compare against the post-write count so DONE follows the final
        // write directly instead of idling one extra cycle in DRAIN.
        if (wr_cnt_nxt == n_rows) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_int  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The delay line only shifts on enabled cycles, so feeding it the ungated
  // issue strobe is equivalent to feeding it rdEn.
  enable_delay_line #(
    .DEPTH(RD_LATENCY)
  ) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .din   (rd_en),
    .dout  (dl_q)
  );

  assign rdEn       = enable & rd_en;
  assign rdAddr     = rd_cnt;
  assign addInReady = enable & dl_q;
  assign wrEn       = enable & wr_en;
  assign wrAddr     = wr_cnt;
  assign busy       = (state != IDLE);
  assign done       = enable & done_int;
  assign err        = err_q;
  assign dbg_state  = state;

`ifdef MATRIX_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (enable) begin
      if ((state == IDLE) && start) begin
        cycle_cnt <= '0;
      end else if (state != IDLE) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end

  assign cycleCount = cycle_cnt;
`endif

endmodule

// File: tb/tb_matrix_add_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_add_row_sequencer
//   Bench for matrix_add_row_sequencer. The vector adder is modelled with an
//   enable_delay_line of depth ADD_LATENCY; an extra spur input lets the
//   bench inject stray outReady pulses. Expected read/write row sequences,
//   done timing and err are derived from the operation rules alone.
// ---------------------------------------------------------------------------
module tb_matrix_add_row_sequencer;
  import matrix_add_pkg::*;

  localparam int ROWS    = 10;
  localparam int ADD_LAT = 1;
  localparam int RD_LAT  = 1;
  localparam int ROW_W   = $clog2(ROWS + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic [ROW_W-1:0] numRows;
  logic             rdEn;
  logic [ROW_W-1:0] rdAddr;
  logic             addInReady;
  logic             addOutReady;
  logic             wrEn;
  logic [ROW_W-1:0] wrAddr;
  logic             busy;
  logic             done;
  logic             err;
  seq_state_e       dbg_state;
  logic             add_q;
  logic             spur;
`ifdef MATRIX_SEQ_PERF_CNT_EN
  logic [31:0]      cycleCount;
`endif

  int checks   = 0;
  int failures = 0;

  logic [ROW_W-1:0] exp_rd_q[$];
  logic [ROW_W-1:0] exp_wr_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT and adder model ----------------
  matrix_add_row_sequencer #(
    .ROWS(ROWS), .COLS(12), .ADD_LATENCY(ADD_LAT), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .numRows(numRows), .rdEn(rdEn), .rdAddr(rdAddr),
    .addInReady(addInReady), .addOutReady(addOutReady),
    .wrEn(wrEn), .wrAddr(wrAddr), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
`ifdef MATRIX_SEQ_PERF_CNT_EN
    , .cycleCount(cycleCount)
`endif
  );

  enable_delay_line #(.DEPTH(ADD_LAT)) u_adder_model (
    .clk(clk), .reset(reset), .enable(enable), .din(addInReady), .dout(add_q)
  );

  assign addOutReady = add_q | spur;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; enable = 1'b1; spur = 1'b0; numRows = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Run one operation. Expected reads/writes are rows 0..eff-1 in order;
  // done lands latency_total-1 enabled cycles after the start cycle.
  task automatic run_op(input int n_req, input bit rand_en, input int stall_after,
                        input int stall_len, input bit poke_start, input bit exp_err);
    int eff, lat, en_off, real_off, done_off, done_real, stall_left, stall_cnt;
    int rd_seen, in_cnt, first_rd, first_wr;
    bit poked;
    logic [31:0] e;
    eff = (n_req > ROWS) ? ROWS : n_req;
    lat = latency_total(eff, RD_LAT, ADD_LAT);
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < eff; i++) begin
      exp_rd_q.push_back(ROW_W'(i));
      exp_wr_q.push_back(ROW_W'(i));
    end
    en_off = 0; real_off = 0; done_off = -1; done_real = -1;
    stall_left = 0; stall_cnt = 0; rd_seen = 0; in_cnt = 0;
    first_rd = -1; first_wr = -1; poked = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; numRows = ROW_W'(n_req); enable = 1'b1; spur = 1'b0;
    @(negedge clk);
    check("start_cycle_busy", {31'd0, busy}, 32'd0);

    for (int cyc = 0; cyc < 300 && done_off < 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (stall_left > 0) begin
        enable = 1'b0; stall_left--; stall_cnt++;
      end else if (rand_en && $urandom_range(3) == 0) begin
        enable = 1'b0; stall_cnt++;
      end else begin
        enable = 1'b1;
      end
      if (poke_start && !poked && rd_seen == 2 && enable) begin
        start = 1'b1; numRows = ROW_W'($urandom_range(ROWS)); poked = 1'b1;
      end
      real_off++;
      if (enable) en_off++;
      @(negedge clk);
      if (!enable) begin
        check("stall_strobes", {28'd0, rdEn, addInReady, wrEn, done}, 32'd0);
      end else begin
        if (rdEn) begin
          rd_seen++;
          if (first_rd < 0) first_rd = en_off;
          e = (exp_rd_q.size() > 0) ? 32'(exp_rd_q.pop_front()) : 32'hFFFF_FFFF;
          check("rd_addr", 32'(rdAddr), e);
          if (stall_after >= 0 && rd_seen == stall_after) stall_left = stall_len;
        end
        if (addInReady) in_cnt++;
        if (wrEn) begin
          if (first_wr < 0) first_wr = en_off;
          e = (exp_wr_q.size() > 0) ? 32'(exp_wr_q.pop_front()) : 32'hFFFF_FFFF;
          check("wr_addr", 32'(wrAddr), e);
        end
        if (done) begin
          done_off  = en_off;
          done_real = real_off;
        end
      end
    end

    check("done_latency", 32'(done_off), 32'(lat - 1));
    check("done_real_time", 32'(done_real), 32'(lat - 1 + stall_cnt));
    check("rows_read", 32'(exp_rd_q.size()), 32'd0);
    check("rows_written", 32'(exp_wr_q.size()), 32'd0);
    check("in_ready_count", 32'(in_cnt), 32'(eff));
    if (eff > 0) begin
      check("first_wr_latency", 32'(first_wr - first_rd), 32'(RD_LAT + ADD_LAT));
    end

    @(posedge clk); #1;
    enable = 1'b1; start = 1'b0;
    @(negedge clk);
    check("post_done_busy", {31'd0, busy}, 32'd0);
    check("post_done_pulse", {31'd0, done}, 32'd0);
    check("err_flag", {31'd0, err}, {31'd0, exp_err});
`ifdef MATRIX_SEQ_PERF_CNT_EN
    check("cycle_count", cycleCount, 32'(lat - 1));
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int done_cnt;
    reset = 1'b1; enable = 1'b1; start = 1'b0; spur = 1'b0; numRows = '0;
    do_reset();
    @(negedge clk);
    check("rst_rdEn", {31'd0, rdEn}, 32'd0);
    check("rst_addInReady", {31'd0, addInReady}, 32'd0);
    check("rst_wrEn", {31'd0, wrEn}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdAddr", 32'(rdAddr), 32'd0);
    check("rst_wrAddr", 32'(wrAddr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // nominal, zero rows, enable stall after the second read
    run_op(10, 1'b0, -1, 0, 1'b0, 1'b0);
`ifdef MATRIX_SEQ_PERF_CNT_EN
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("cycle_count_hold", cycleCount, 32'd13);
    end
`endif
    run_op(0, 1'b0, -1, 0, 1'b0, 1'b0);
    run_op(4, 1'b0, 2, 3, 1'b0, 1'b0);

    // randomized row counts with random enable drops
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(ROWS);
      run_op(n, 1'b1, -1, 0, 1'b0, 1'b0);
    end

`ifdef MATRIX_SEQ_PERF_CNT_EN
    @(posedge clk); #1;
    start = 1'b1; numRows = ROW_W'(2); enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cycle_count_clear", cycleCount, 32'd0);
    repeat (6) @(posedge clk);
    #1;
`endif

    // start while busy is ignored but flagged
    do_reset();
    run_op(6, 1'b0, -1, 0, 1'b1, 1'b1);

    // oversize row count is clamped to ROWS and flagged
    do_reset();
    run_op(15, 1'b0, -1, 0, 1'b0, 1'b1);

    // stray adder outReady in IDLE: no write, flagged
    do_reset();
    @(posedge clk); #1;
    spur = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("spur_wrEn", {31'd0, wrEn}, 32'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("spur_err", {31'd0, err}, 32'd1);

    // reset in the middle of DRAIN aborts with no done pulse
    do_reset();
    @(posedge clk); #1;
    start = 1'b1; numRows = ROW_W'(5); enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (dbg_state == DRAIN) break;
    end
    check("reach_drain", 32'(dbg_state), 32'(DRAIN));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {21'd0, rdEn, addInReady, wrEn, done, busy, err,
                            rdAddr, wrAddr} , 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done || wrEn) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(3, 1'b0, -1, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
